// File: rtl/arc_sequencer_if.sv
// Control/status bundle between the ARC sequencer and the datapath.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface arc_sequencer_if;
  logic [1:0]  op;
  logic [2:0]  op2;
  logic [5:0]  op3;
  logic        cond_true;
  logic        mem_ready;
  logic [12:0] state;
  logic        mem_req;
  logic        mem_we;
  logic        ir_ld;
  logic        pc_ld;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic        psr_ld;
  logic        fault;
  logic [1:0]  fault_code;

  modport master (
    input  op, op2, op3, cond_true, mem_ready,
    output state, mem_req, mem_we, ir_ld, pc_ld, pc_sel, rf_we, rf_wsel, psr_ld,
    output fault, fault_code
  );

  modport slave (
    output op, op2, op3, cond_true, mem_ready,
    input  state, mem_req, mem_we, ir_ld, pc_ld, pc_sel, rf_we, rf_wsel, psr_ld,
    input  fault, fault_code
  );
endinterface

// File: rtl/arc_sequencer.sv
// One-hot ARC control sequencer: fetch/decode/execute/memory phases with memory wait timeout,
// illegal-opcode and corrupt-state detection, all ending in a sticky HALT.
module arc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic           clk,
  input  logic           preset,
  arc_sequencer_if.master bus
);

  typedef enum logic [12:0] {
    StIf    = 13'h0001,
    StIfw   = 13'h0002,
    StId    = 13'h0004,
    StAlu   = 13'h0008,
    StSethi = 13'h0010,
    StBr    = 13'h0020,
    StCall  = 13'h0040,
    StMa    = 13'h0080,
    StLdw   = 13'h0100,
    StStw   = 13'h0200,
    StWb    = 13'h0400,
    StPcinc = 13'h0800,
    StHalt  = 13'h1000
  } state_e;

  localparam logic [CNT_W-1:0] TimeoutLast =
      (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  // Plain vector so an illegal (non-one-hot) value can be represented and detected.
  logic [12:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;

  logic       onehot, timeout_hit;
  logic       req, we, ir, pl, rw, psr;
  logic [1:0] ps, ws;

  assign onehot      = (state_q != '0) && ((state_q & (state_q - 13'd1)) == '0);
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == TimeoutLast) && !bus.mem_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    fault_d = fault_q;
    code_d  = code_q;
    req     = 1'b0;
    we      = 1'b0;
    ir      = 1'b0;
    pl      = 1'b0;
    ps      = 2'b00;
    rw      = 1'b0;
    ws      = 2'b00;
    psr     = 1'b0;
    if (!onehot) begin
      state_d = StHalt;
      fault_d = 1'b1;
      code_d  = 2'b11;
    end else begin
      unique case (state_q)
        StIf: begin
          req     = 1'b1;
          state_d = StIfw;
        end
        StIfw, StLdw, StStw: begin
          req = 1'b1;
          we  = (state_q == StStw);
          if (timeout_hit) begin
            state_d = StHalt;
            fault_d = 1'b1;
            code_d  = 2'b10;
          end else if (bus.mem_ready) begin
            ir = (state_q == StIfw);
            unique case (state_q)
              StIfw:   state_d = StId;
              StLdw:   state_d = StWb;
              default: state_d = StPcinc;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StId: begin
          if (bus.op == 2'b01)                            state_d = StCall;
          else if (bus.op == 2'b00 && bus.op2 == 3'b100)  state_d = StSethi;
          else if (bus.op == 2'b00 && bus.op2 == 3'b010)  state_d = StBr;
          else if (bus.op == 2'b10)                       state_d = StAlu;
          else if (bus.op == 2'b11 && (bus.op3 == 6'b000000 || bus.op3 == 6'b000100))
            state_d = StMa;
          else begin
            state_d = StHalt;
            fault_d = 1'b1;
            code_d  = 2'b01;
          end
        end
        StAlu: begin
          rw = 1'b1;
          if (bus.op3 == 6'b111000) begin
            ws      = 2'b01;
            pl      = 1'b1;
            ps      = 2'b11;
            state_d = StIf;
          end else begin
            psr     = bus.op3[4];
            state_d = StPcinc;
          end
        end
        StSethi: begin
          rw      = 1'b1;
          ws      = 2'b10;
          state_d = StPcinc;
        end
        StBr: begin
          if (bus.cond_true) begin
            pl      = 1'b1;
            ps      = 2'b01;
            state_d = StIf;
          end else begin
            state_d = StPcinc;
          end
        end
        StCall: begin
          rw      = 1'b1;
          ws      = 2'b01;
          pl      = 1'b1;
          ps      = 2'b10;
          state_d = StIf;
        end
        StMa: begin
          if (bus.op3 == 6'b000000)      state_d = StLdw;
          else if (bus.op3 == 6'b000100) state_d = StStw;
          else begin
            state_d = StHalt;
            fault_d = 1'b1;
            code_d  = 2'b01;
          end
        end
        StWb: begin
          rw      = 1'b1;
          ws      = 2'b11;
          state_d = StPcinc;
        end
        StPcinc: begin
          pl      = 1'b1;
          state_d = StIf;
        end
        default: state_d = StHalt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      state_q <= StIf;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.mem_req    = req & ~preset;
  assign bus.mem_we     = we & ~preset;
  assign bus.ir_ld      = ir & ~preset;
  assign bus.pc_ld      = pl & ~preset;
  assign bus.pc_sel     = preset ? 2'b00 : ps;
  assign bus.rf_we      = rw & ~preset;
  assign bus.rf_wsel    = preset ? 2'b00 : ws;
  assign bus.psr_ld     = psr & ~preset;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_arc_sequencer.sv
// Directed bench for arc_sequencer: expected state/strobes are queued per cycle and
// popped for comparison at mid-cycle (negedge + 1).
module tb_arc_sequencer;

  localparam logic [12:0] SIf    = 13'h0001;
  localparam logic [12:0] SIfw   = 13'h0002;
  localparam logic [12:0] SId    = 13'h0004;
  localparam logic [12:0] SAlu   = 13'h0008;
  localparam logic [12:0] SBr    = 13'h0020;
  localparam logic [12:0] SMa    = 13'h0080;
  localparam logic [12:0] SLdw   = 13'h0100;
  localparam logic [12:0] SWb    = 13'h0400;
  localparam logic [12:0] SPcinc = 13'h0800;
  localparam logic [12:0] SHalt  = 13'h1000;

  typedef struct {
    string       tag;
    logic [12:0] st;
    logic [12:0] sg;
  } exp_t;

  logic clk = 1'b0;
  logic preset;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];

  arc_sequencer_if bus ();

  arc_sequencer #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk    (clk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, ir_ld, pc_ld, pc_sel, rf_we, rf_wsel, psr_ld, fault, fault_code}
  function automatic logic [12:0] sg(input logic mr, input logic mw, input logic ir,
                                     input logic pl, input logic [1:0] ps, input logic rw,
                                     input logic [1:0] ws, input logic psr, input logic f,
                                     input logic [1:0] fc);
    return {mr, mw, ir, pl, ps, rw, ws, psr, f, fc};
  endfunction

  // Push expectation for the current cycle, sample the DUT, pop and compare, then advance.
  task automatic cyc(input string tag, input logic [12:0] st, input logic [12:0] s);
    exp_t e;
    logic [12:0] obs_sg;
    exp_q.push_back('{tag: tag, st: st, sg: s});
    #1;
    e      = exp_q.pop_front();
    obs_sg = {bus.mem_req, bus.mem_we, bus.ir_ld, bus.pc_ld, bus.pc_sel, bus.rf_we,
              bus.rf_wsel, bus.psr_ld, bus.fault, bus.fault_code};
    total_cnt++;
    assert (bus.state === e.st && obs_sg === e.sg) pass_cnt++;
    else $error("FAIL %s: state=%h strobes=%b, required state=%h strobes=%b",
                e.tag, bus.state, obs_sg, e.st, e.sg);
    @(negedge clk);
  endtask

  logic [12:0] z, f_if, f_ifw, f_ifw_ir, f_pc;

  initial begin
    z        = sg(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00);
    f_if     = sg(1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00);
    f_ifw    = f_if;
    f_ifw_ir = sg(1, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b00);
    f_pc     = sg(0, 0, 0, 1, 2'b00, 0, 2'b00, 0, 0, 2'b00);

    preset        = 1'b1;
    bus.op        = 2'b10;
    bus.op2       = 3'b000;
    bus.op3       = 6'b000000;
    bus.cond_true = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);

    // Reset held two cycles: IF with every strobe forced low.
    cyc("rst0", SIf, z);
    cyc("rst1", SIf, z);
    preset = 1'b0;

    // ADD then ADDcc.
    cyc("add_if", SIf, f_if);
    cyc("add_ifw", SIfw, f_ifw_ir);
    cyc("add_id", SId, z);
    cyc("add_alu", SAlu, sg(0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0, 2'b00));
    cyc("add_pcinc", SPcinc, f_pc);
    bus.op3 = 6'b010000;
    cyc("addcc_if", SIf, f_if);
    cyc("addcc_ifw", SIfw, f_ifw_ir);
    cyc("addcc_id", SId, z);
    cyc("addcc_alu", SAlu, sg(0, 0, 0, 0, 2'b00, 1, 2'b00, 1, 0, 2'b00));
    cyc("addcc_pcinc", SPcinc, f_pc);

    // LD with three memory wait cycles in LDW.
    bus.op  = 2'b11;
    bus.op3 = 6'b000000;
    cyc("ld_if", SIf, f_if);
    cyc("ld_ifw", SIfw, f_ifw_ir);
    cyc("ld_id", SId, z);
    cyc("ld_ma", SMa, z);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ld_wait", SLdw, f_if);
    bus.mem_ready = 1'b1;
    cyc("ld_ldw", SLdw, f_if);
    cyc("ld_wb", SWb, sg(0, 0, 0, 0, 2'b00, 1, 2'b11, 0, 0, 2'b00));
    cyc("ld_pcinc", SPcinc, f_pc);

    // Branch taken, then not taken.
    bus.op        = 2'b00;
    bus.op2       = 3'b010;
    bus.cond_true = 1'b1;
    cyc("bt_if", SIf, f_if);
    cyc("bt_ifw", SIfw, f_ifw_ir);
    cyc("bt_id", SId, z);
    cyc("bt_br", SBr, sg(0, 0, 0, 1, 2'b01, 0, 2'b00, 0, 0, 2'b00));
    bus.cond_true = 1'b0;
    cyc("bn_if", SIf, f_if);
    cyc("bn_ifw", SIfw, f_ifw_ir);
    cyc("bn_id", SId, z);
    cyc("bn_br", SBr, z);
    cyc("bn_pcinc", SPcinc, f_pc);

    // Fetch timeout: exactly 15 IFW cycles, then HALT with code 10.
    bus.mem_ready = 1'b0;
    cyc("to_if", SIf, f_if);
    for (int i = 0; i < 15; i++) cyc("to_ifw", SIfw, f_ifw);
    cyc("to_halt", SHalt, sg(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b10));
    cyc("to_halt2", SHalt, sg(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b10));
    preset = 1'b1;
    cyc("to_rst_halt", SHalt, sg(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b10));
    cyc("to_rst_if", SIf, z);
    preset = 1'b0;

    // mem_ready arriving in the 15th cycle is accepted.
    bus.op  = 2'b10;
    bus.op3 = 6'b000000;
    cyc("last_if", SIf, f_if);
    for (int i = 0; i < 14; i++) cyc("last_ifw", SIfw, f_ifw);
    bus.mem_ready = 1'b1;
    cyc("last_ifw15", SIfw, f_ifw_ir);
    cyc("last_id", SId, z);
    cyc("last_alu", SAlu, sg(0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0, 2'b00));
    cyc("last_pcinc", SPcinc, f_pc);

    // Illegal opcode.
    bus.op  = 2'b11;
    bus.op3 = 6'b111111;
    cyc("ill_if", SIf, f_if);
    cyc("ill_ifw", SIfw, f_ifw_ir);
    cyc("ill_id", SId, z);
    cyc("ill_halt", SHalt, sg(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b01));
    preset = 1'b1;
    cyc("ill_rst", SHalt, sg(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b01));
    preset = 1'b0;
    cyc("ill_if2", SIf, f_if);

    // Corrupt state: two bits set.
    force dut.state_q = 13'h0003;
    cyc("bad_state", 13'h0003, z);
    release dut.state_q;
    @(negedge clk);
    cyc("bad_halt", SHalt, sg(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 2'b11));
    preset = 1'b1;
    @(negedge clk);
    preset = 1'b0;
    cyc("bad_clear", SIf, f_if);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/arc_sequencer.md
Name: arc_sequencer

Overview:
- One-hot control sequencer for the ARC processor control unit.
- Holds the 13-bit one-hot state and computes next-state logic for fetch, decode, execute and memory phases.
- Drives the datapath strobes: IR, PC, register file, PSR and the memory request.
- Adds memory wait-state handling with a timeout, illegal-opcode detection and corrupt-state detection, each leading to a sticky HALT.

Parameters:
- MEM_TIMEOUT, 15, maximum cycles spent in one memory wait state before a fault; 0 disables the timeout.
- CNT_W, 8, width of the wait-cycle counter; must satisfy MEM_TIMEOUT < 2^CNT_W.

Ports:
- clk  input  1  clock, rising edge.
- preset  input  1  synchronous active-high reset to IF.
- op  input  2  IR[31:30].
- op2  input  3  IR[24:22].
- op3  input  6  IR[24:19].
- cond_true  input  1  branch condition evaluated from PSR and IR cond; valid in BR.
- mem_ready  input  1  memory completes the current access this cycle.
- state  output  13  current one-hot state.
- mem_req  output  1  memory access request.
- mem_we  output  1  write qualifier for mem_req.
- ir_ld  output  1  load IR from memory data.
- pc_ld  output  1  load PC.
- pc_sel  output  2  PC source: 00 PC+4, 01 branch displacement, 10 call displacement, 11 JMPL target.
- rf_we  output  1  register file write enable.
- rf_wsel  output  2  write-back source: 00 ALU, 01 PC, 10 SETHI immediate, 11 memory data.
- psr_ld  output  1  load condition codes.
- fault  output  1  sticky; set on entry to HALT.
- fault_code  output  2  01 illegal opcode, 10 memory timeout, 11 corrupt state; 00 when fault=0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on preset.
- State encoding (bit index): IF0 IFW1 ID2 ALU3 SETHI4 BR5 CALL6 MA7 LDW8 STW9 WB10 PCINC11 HALT12.
- Reset: a posedge with preset=1 loads state=13'h0001 (IF) and clears fault, fault_code and the wait counter.
  - While preset=1, every strobe output is forced to 0. preset overrides all other activity, including mid-wait and HALT.
- State register updates on posedge clk only. Strobes are combinational from the current state, mem_ready and cond_true.
- IF: mem_req=1 -> IFW.
- IFW: mem_req=1.
  - mem_ready=1: ir_ld=1, -> ID.
  - Otherwise stay in IFW.
- ID: no strobes. Decode:
  - op=01 -> CALL.
  - op=00, op2=100 -> SETHI.
  - op=00, op2=010 -> BR.
  - op=10 -> ALU.
  - op=11 with op3=000000 or 000100 -> MA.
  - Any other op=00 or op=11 code -> HALT, fault_code=01.
- ALU:
  - op3=111000 (JMPL): rf_we=1, rf_wsel=01, pc_ld=1, pc_sel=11, -> IF.
  - Otherwise: rf_we=1, rf_wsel=00, psr_ld=op3[4], -> PCINC.
- SETHI: rf_we=1, rf_wsel=10, -> PCINC.
- BR:
  - cond_true=1: pc_ld=1, pc_sel=01, -> IF.
  - Otherwise -> PCINC.
- CALL: rf_we=1, rf_wsel=01, pc_ld=1, pc_sel=10, -> IF.
- MA: address-compute cycle, no strobes.
  - op3=000000 -> LDW.
  - op3=000100 -> STW.
- LDW: mem_req=1. mem_ready=1 -> WB; otherwise stay.
- STW: mem_req=1, mem_we=1. mem_ready=1 -> PCINC; otherwise stay.
- WB: rf_we=1, rf_wsel=11, -> PCINC.
- PCINC: pc_ld=1, pc_sel=00, -> IF.
- HALT: all strobes 0. Stays in HALT until preset.
- Wait counter (IFW, LDW, STW):
  - Cleared to 0 on every cycle spent outside a wait state.
  - Increments each wait cycle with mem_ready=0.
  - If MEM_TIMEOUT≠0, counter=MEM_TIMEOUT-1 and mem_ready=0: -> HALT, fault_code=10. A wait state therefore lasts at most MEM_TIMEOUT cycles.
  - mem_ready in the final allowed cycle is accepted; the timeout does not fire.
- Corrupt state: state not one-hot (zero or multiple bits set) -> strobes 0, next HALT, fault_code=11.
- fault and fault_code are registered: set on the edge entering HALT and held until preset.
- Instruction latency with zero memory wait (mem_ready=1 on first IFW cycle):
  - ALU, SETHI: 5 cycles.
  - Taken branch, CALL, JMPL: 4 cycles.
  - LD: 7 cycles. ST: 6 cycles.

Test Plan:
- preset=1 for 2 cycles, then 0 -> state=13'h0001, mem_req=1 in first cycle after release, fault=0; strobes are 0 while preset=1.
- ADD (op=10, op3=000000), mem_ready always 1 -> states IF,IFW,ID,ALU,PCINC,IF; rf_we=1/rf_wsel=00 in ALU, psr_ld=0; ADDcc (op3=010000) gives psr_ld=1.
- LD (op=11, op3=000000), mem_ready low 3 cycles in LDW -> 4 LDW cycles then WB with rf_wsel=11, then PCINC with pc_sel=00.
- BR (op=00, op2=010), cond_true=1 -> pc_ld=1, pc_sel=01 in BR, next IF; cond_true=0 -> PCINC.
- MEM_TIMEOUT=15, mem_ready held 0 in IFW -> exactly 15 IFW cycles, then HALT, fault=1, fault_code=10; preset clears to IF with fault=0. mem_ready on the 15th cycle -> ID, no fault.
- op=11, op3=111111 -> ID then HALT, fault_code=01; force state=13'h0003 -> HALT, fault_code=11.
